pipe_reg_sf: RTL and testbench



---
 rtl/pipe_reg_sf.sv | 133 +++++++++++++
 tb/tb_pipe_reg_sf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_sf.sv
// Multi-stage execute-to-memory pipeline register with valid tracking, stall, flush
// and a combinational register-forwarding lookup over the in-flight stages.
module pipe_reg_sf #(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int STAGES              = 2,
    parameter int OCC_BITS            = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    input  logic                           stall,
    input  logic                           flush,
    input  logic [DBITS-1:0]               aluOut,
    input  logic [DBITS-1:0]               PCinc,
    input  logic [DBITS-1:0]               dmemDataIn,
    input  logic                           dmemWrtEn,
    input  logic                           memtoReg,
    input  logic                           jal,
    input  logic                           regFileWrtEn,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] regWrtIndex,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] fwd_idx,
    output logic                           valid_out,
    output logic [DBITS-1:0]               dmemAddr_out,
    output logic [DBITS-1:0]               regFileAluOut_out,
    output logic [DBITS-1:0]               dmemDataIn_out,
    output logic [DBITS-1:0]               PCinc_out,
    output logic                           dmemWrtEn_out,
    output logic                           regFileWrtEn_out,
    output logic                           memtoReg_out,
    output logic                           jal_out,
    output logic [REG_INDEX_BIT_WIDTH-1:0] regWrtIndex_out,
    output logic                           fwd_hit,
    output logic [DBITS-1:0]               fwd_data,
    output logic                           fwd_load_hazard,
    output logic [OCC_BITS-1:0]            occupancy
);

    typedef struct packed {
        logic                           valid;
        logic [DBITS-1:0]               alu;
        logic [DBITS-1:0]               pcinc;
        logic [DBITS-1:0]               ddata;
        logic                           dmem_we;
        logic                           mem2reg;
        logic                           jal;
        logic                           rf_we;
        logic [REG_INDEX_BIT_WIDTH-1:0] widx;
    } stage_t;

    // Index 0 is the youngest stage, STAGES-1 drives the outputs.
    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    stage_t in_s;
    stage_t last_s;

    always_comb begin
        in_s = '{valid: valid_in, alu: aluOut, pcinc: PCinc, ddata: dmemDataIn,
                 dmem_we: dmemWrtEn, mem2reg: memtoReg, jal: jal,
                 rf_we: regFileWrtEn, widx: regWrtIndex};
    end

    // NOTE: every stage is defaulted to its current value before any branch, so no
    // path through this block leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_d[k].valid = 1'b0;
            end
        end else if (!stall) begin
            stage_d[0] = in_s;
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    // NOTE: payload is reset along with the valid bits so the outputs read 0 after
    // reset; state is written with non-blocking assignments so all stages shift at once.
    always_ff @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_BITS'(stage_q[k].valid);
        end
    end

    // Walk oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
        fwd_hit         = 1'b0;
        fwd_data        = '0;
        fwd_load_hazard = 1'b0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (stage_q[k].valid && stage_q[k].rf_we && !stage_q[k].jal &&
                stage_q[k].widx == fwd_idx) begin
                if (stage_q[k].mem2reg) begin
                    fwd_hit         = 1'b0;
                    fwd_data        = '0;
                    fwd_load_hazard = 1'b1;
                end else begin
                    fwd_hit         = 1'b1;
                    fwd_data        = stage_q[k].alu;
                    fwd_load_hazard = 1'b0;
                end
            end
        end
    end

    always_comb begin
        last_s            = stage_q[STAGES-1];
        valid_out         = last_s.valid;
        dmemAddr_out      = last_s.alu;
        regFileAluOut_out = last_s.alu;
        dmemDataIn_out    = last_s.ddata;
        PCinc_out         = last_s.pcinc;
        dmemWrtEn_out     = last_s.dmem_we & last_s.valid;
        regFileWrtEn_out  = last_s.rf_we & last_s.valid;
        memtoReg_out      = last_s.mem2reg;
        jal_out           = last_s.jal;
        regWrtIndex_out   = last_s.widx;
    end

endmodule

// File: tb/tb_pipe_reg_sf.sv
// Scoreboard bench for pipe_reg_sf: the driver pushes expected per-cycle outputs from an
// instruction-queue reference model; a monitor pops and compares after each negedge.
module tb_pipe_reg_sf;

    localparam int DBITS    = 32;
    localparam int RIW      = 4;
    localparam int STAGES   = 2;
    localparam int OCC_BITS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, valid_in, stall, flush;
    logic [DBITS-1:0] aluOut, PCinc, dmemDataIn;
    logic             dmemWrtEn, memtoReg, jal, regFileWrtEn;
    logic [RIW-1:0]   regWrtIndex, fwd_idx;
    logic             valid_out;
    logic [DBITS-1:0] dmemAddr_out, regFileAluOut_out, dmemDataIn_out, PCinc_out;
    logic             dmemWrtEn_out, regFileWrtEn_out, memtoReg_out, jal_out;
    logic [RIW-1:0]   regWrtIndex_out;
    logic             fwd_hit, fwd_load_hazard;
    logic [DBITS-1:0] fwd_data;
    logic [OCC_BITS-1:0] occupancy;

    pipe_reg_sf #(.DBITS(DBITS), .REG_INDEX_BIT_WIDTH(RIW), .STAGES(STAGES),
                  .OCC_BITS(OCC_BITS)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
        .aluOut(aluOut), .PCinc(PCinc), .dmemDataIn(dmemDataIn),
        .dmemWrtEn(dmemWrtEn), .memtoReg(memtoReg), .jal(jal),
        .regFileWrtEn(regFileWrtEn), .regWrtIndex(regWrtIndex), .fwd_idx(fwd_idx),
        .valid_out(valid_out), .dmemAddr_out(dmemAddr_out),
        .regFileAluOut_out(regFileAluOut_out), .dmemDataIn_out(dmemDataIn_out),
        .PCinc_out(PCinc_out), .dmemWrtEn_out(dmemWrtEn_out),
        .regFileWrtEn_out(regFileWrtEn_out), .memtoReg_out(memtoReg_out),
        .jal_out(jal_out), .regWrtIndex_out(regWrtIndex_out), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .fwd_load_hazard(fwd_load_hazard), .occupancy(occupancy)
    );

    typedef struct {
        bit              valid;
        logic [DBITS-1:0] alu, pcinc, ddata;
        bit              dwe, m2r, jal, rwe;
        logic [RIW-1:0]  widx;
    } instr_t;

    typedef struct {
        instr_t           last;
        int               occ;
        bit               hit, haz;
        logic [DBITS-1:0] fdata;
    } exp_t;

    instr_t pipe[$];
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic instr_t mk(bit v, logic [DBITS-1:0] alu, logic [RIW-1:0] widx,
                                  bit rwe, bit m2r, bit j, bit dwe);
        instr_t s;
        s.valid = v;  s.alu = alu;  s.pcinc = alu + 32'h4;  s.ddata = ~alu;
        s.dwe = dwe;  s.m2r = m2r;  s.jal = j;  s.rwe = rwe;  s.widx = widx;
        return s;
    endfunction

    function automatic instr_t rnd(bit v);
        instr_t s;
        s.valid = v;
        s.alu = $urandom;  s.pcinc = $urandom;  s.ddata = $urandom;
        s.dwe = 1'($urandom);  s.m2r = 1'($urandom_range(0, 3) == 0);
        s.jal = 1'($urandom_range(0, 3) == 0);  s.rwe = 1'($urandom);
        s.widx = RIW'($urandom_range(0, 3));
        return s;
    endfunction

    // One clock period: present inputs, advance the reference model, queue the outcome.
    task automatic cycle(bit rst, bit fl, bit st, instr_t in, logic [RIW-1:0] fidx);
        exp_t e;
        int   hits[$];
        instr_t zero;
        @(posedge clk);
        reset = rst;  flush = fl;  stall = st;  valid_in = in.valid;
        aluOut = in.alu;  PCinc = in.pcinc;  dmemDataIn = in.ddata;
        dmemWrtEn = in.dwe;  memtoReg = in.m2r;  jal = in.jal;
        regFileWrtEn = in.rwe;  regWrtIndex = in.widx;  fwd_idx = fidx;
        zero = '{default: '0};
        if (rst) begin
            pipe.delete();
            repeat (STAGES) pipe.push_back(zero);
        end else if (fl) begin
            foreach (pipe[i]) pipe[i].valid = 1'b0;
        end else if (!st) begin
            pipe.push_front(in);
            void'(pipe.pop_back());
        end
        e.last = pipe[STAGES-1];
        e.occ  = 0;
        foreach (pipe[i]) if (pipe[i].valid) e.occ++;
        hits = pipe.find_first_index with (item.valid && item.rwe && !item.jal &&
                                           item.widx == fidx);
        e.hit = 1'b0;  e.haz = 1'b0;  e.fdata = '0;
        if (hits.size() != 0) begin
            if (pipe[hits[0]].m2r) e.haz = 1'b1;
            else begin
                e.hit   = 1'b1;
                e.fdata = pipe[hits[0]].alu;
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("valid_out",         64'(valid_out),         64'(mon_e.last.valid));
                check("dmemAddr_out",      64'(dmemAddr_out),      64'(mon_e.last.alu));
                check("regFileAluOut_out", 64'(regFileAluOut_out), 64'(mon_e.last.alu));
                check("dmemDataIn_out",    64'(dmemDataIn_out),    64'(mon_e.last.ddata));
                check("PCinc_out",         64'(PCinc_out),         64'(mon_e.last.pcinc));
                check("dmemWrtEn_out",     64'(dmemWrtEn_out),
                      64'(mon_e.last.dwe && mon_e.last.valid));
                check("regFileWrtEn_out",  64'(regFileWrtEn_out),
                      64'(mon_e.last.rwe && mon_e.last.valid));
                check("memtoReg_out",      64'(memtoReg_out),      64'(mon_e.last.m2r));
                check("jal_out",           64'(jal_out),           64'(mon_e.last.jal));
                check("regWrtIndex_out",   64'(regWrtIndex_out),   64'(mon_e.last.widx));
                check("occupancy",         64'(occupancy),         64'(mon_e.occ));
                check("fwd_hit",           64'(fwd_hit),           64'(mon_e.hit));
                check("fwd_data",          64'(fwd_data),          64'(mon_e.fdata));
                check("fwd_load_hazard",   64'(fwd_load_hazard),   64'(mon_e.haz));
            end
        end
    end

    initial begin
        instr_t idle, a, b, s, c;
        reset = 1'b1;  valid_in = 1'b0;  stall = 1'b0;  flush = 1'b0;
        aluOut = '0;  PCinc = '0;  dmemDataIn = '0;  dmemWrtEn = 1'b0;
        memtoReg = 1'b0;  jal = 1'b0;  regFileWrtEn = 1'b0;  regWrtIndex = '0;  fwd_idx = '0;
        idle = mk(0, 32'h0, 4'd0, 0, 0, 0, 0);
        a    = mk(1, 32'h10, 4'd3, 1, 0, 0, 0);
        s    = mk(1, 32'h40, 4'd0, 0, 0, 0, 1);
        c    = mk(1, 32'h55, 4'd5, 1, 0, 0, 0);

        // Reset, idle, then A/B streaming with youngest-match forwarding.
        cycle(1, 0, 0, rnd(1), 4'd0);
        cycle(0, 0, 0, idle, 4'd0);
        cycle(0, 0, 0, idle, 4'd0);
        b = mk(1, 32'h20, 4'd3, 1, 0, 0, 0);
        cycle(0, 0, 0, a, 4'd3);
        cycle(0, 0, 0, b, 4'd3);
        cycle(0, 0, 0, idle, 4'd3);

        // Youngest match is a load: hazard, older A ignored.
        cycle(1, 0, 0, idle, 4'd3);
        b = mk(1, 32'h20, 4'd3, 1, 1, 0, 0);
        cycle(0, 0, 0, a, 4'd3);
        cycle(0, 0, 0, b, 4'd3);

        // Youngest match is a jal: skipped, A forwards instead.
        cycle(1, 0, 0, idle, 4'd3);
        b = mk(1, 32'h20, 4'd3, 1, 0, 1, 0);
        cycle(0, 0, 0, a, 4'd3);
        cycle(0, 0, 0, b, 4'd3);

        // Store held by a three-cycle stall, then released.
        cycle(1, 0, 0, idle, 4'd0);
        cycle(0, 0, 0, s, 4'd0);
        repeat (3) cycle(0, 0, 1, rnd(1), 4'd0);
        cycle(0, 0, 0, idle, 4'd0);
        cycle(0, 0, 0, idle, 4'd0);

        // Flush together with stall kills the in-flight store.
        cycle(0, 0, 0, s, 4'd0);
        cycle(0, 1, 1, rnd(1), 4'd0);
        cycle(0, 0, 0, idle, 4'd0);
        cycle(0, 0, 0, idle, 4'd0);

        // Reset while full, then a fresh instruction travels through.
        cycle(0, 0, 0, a, 4'd3);
        cycle(0, 0, 0, s, 4'd3);
        cycle(1, 0, 0, rnd(1), 4'd3);
        cycle(0, 0, 0, c, 4'd5);
        cycle(0, 0, 0, idle, 4'd5);
        cycle(0, 0, 0, idle, 4'd5);

        // Randomised traffic with occasional reset, flush and stall.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 4) == 0), rnd(1'($urandom_range(0, 9) < 7)),
                  RIW'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
